// File: rtl/axi_read_slave_burst.sv
// AXI read-channel slave: FIXED/INCR/WRAP bursts of up to 16 beats served
// from a registered device port, with narrow-lane masking and SLVERR replies.
//
// Ports:
//   ACLK, ARESETn (async, active-high)        clock / reset
//   address_out, devread, data_in             device read port (data 1 cycle after devread)
//   ARID, ARADDR, ARLEN, ARSIZE, ARBURST,     AR channel
//   ARPROT, ARVALID, ARREADY
//   RID, RDATA, RESP, RLAST, RVALID, RREADY   R channel
module axi_read_slave_burst #(
    parameter int BusWidth = 32,
    parameter int TagBits  = 4,
    parameter int LenBits  = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    output logic [BusWidth-1:0] address_out,
    output logic                devread,
    input  logic [BusWidth-1:0] data_in,
    input  logic [TagBits-1:0]  ARID,
    input  logic [BusWidth-1:0] ARADDR,
    input  logic [LenBits-1:0]  ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic [2:0]          ARPROT,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [TagBits-1:0]  RID,
    output logic [BusWidth-1:0] RDATA,
    output logic [1:0]          RESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int NB = BusWidth / 8;
    localparam int LB = $clog2(NB);
    localparam logic [BusWidth-1:0] ONE = BusWidth'(1);
    localparam logic [BusWidth-1:0] LANE_MASK = BusWidth'(NB - 1);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, SEND} state_t;

    state_t state_q, state_d;

    logic [TagBits-1:0]  id_q;
    logic [BusWidth-1:0] addr_q;
    logic [LenBits-1:0]  len_q;
    logic [LenBits-1:0]  beats_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err_q;

    logic                req_err;
    logic [BusWidth-1:0] req_nbytes;
    logic [BusWidth-1:0] nbytes;
    logic [BusWidth-1:0] wrap_bytes;
    logic [BusWidth-1:0] wrap_lower;
    logic [BusWidth-1:0] next_addr;
    logic [BusWidth-1:0] lane_data;
    logic [LB-1:0]       base_lo;
    int                  lane_lo;
    int                  lane_hi;
    logic                unused_prot;

    assign unused_prot = ^ARPROT;

    // Request legality, evaluated on the AR payload at handshake time.
    assign req_nbytes = ONE << ARSIZE;

    always_comb begin
        req_err = 1'b0;
        if (int'(ARSIZE) > LB)
            req_err = 1'b1;
        if (ARBURST == 2'b11)
            req_err = 1'b1;
        if (ARBURST == 2'b10) begin
            // Wrap length must be 2, 4, 8 or 16 beats.
            if (ARLEN == '0 || (ARLEN & (ARLEN + LenBits'(1))) != '0)
                req_err = 1'b1;
            if ((ARADDR & (req_nbytes - ONE)) != '0)
                req_err = 1'b1;
        end
    end

    // Next-beat address.
    assign nbytes     = ONE << size_q;
    assign wrap_bytes = (BusWidth'(len_q) + ONE) << size_q;
    assign wrap_lower = addr_q & ~(wrap_bytes - ONE);

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            2'b01: next_addr = (addr_q & ~(nbytes - ONE)) + nbytes;
            2'b10: begin
                next_addr = addr_q + nbytes;
                if (next_addr == wrap_lower + wrap_bytes)
                    next_addr = wrap_lower;
            end
            default: next_addr = addr_q;
        endcase
    end

    // Active lanes: from the byte offset up to the end of the
    // nbytes-aligned container; everything else reads as zero.
    assign base_lo = addr_q[LB-1:0] & ~(nbytes[LB-1:0] - LB'(1));

    always_comb begin
        lane_lo   = int'(addr_q[LB-1:0]);
        lane_hi   = int'(base_lo) + int'(nbytes[LB:0]) - 1;
        lane_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= lane_lo && i <= lane_hi)
                lane_data[8*i +: 8] = data_in[8*i +: 8];
        end
    end

    assign address_out = addr_q & ~LANE_MASK;
    assign devread     = (state_q == READ) && !err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ARVALID && ARREADY) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND:    if (RREADY) state_d = RLAST ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            state_q <= IDLE;
            ARREADY <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beats_q <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RESP    <= '0;
            RLAST   <= 1'b0;
            RVALID  <= 1'b0;
        end else begin
            state_q <= state_d;
            ARREADY <= (state_d == IDLE);
            if (state_q == IDLE && ARVALID && ARREADY) begin
                id_q    <= ARID;
                addr_q  <= ARADDR;
                len_q   <= ARLEN;
                beats_q <= ARLEN;
                size_q  <= ARSIZE;
                burst_q <= ARBURST;
                err_q   <= req_err;
            end
            if (state_q == CAPTURE) begin
                RDATA  <= err_q ? '0 : lane_data;
                RID    <= id_q;
                RESP   <= err_q ? 2'b10 : 2'b00;
                RLAST  <= (beats_q == '0);
                RVALID <= 1'b1;
            end
            if (state_q == SEND && RREADY) begin
                RVALID <= 1'b0;
                RLAST  <= 1'b0;
                if (!RLAST) begin
                    addr_q  <= next_addr;
                    beats_q <= beats_q - LenBits'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_read_slave_burst.sv
// Directed scoreboard bench for axi_read_slave_burst.
// Expected device reads and R beats are queued before each burst.
module tb_axi_read_slave_burst;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] address_out;
    logic        devread;
    logic [31:0] data_in;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    axi_read_slave_burst #(.BusWidth(32), .TagBits(4), .LenBits(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .address_out(address_out), .devread(devread), .data_in(data_in),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARPROT(ARPROT), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RESP(RESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_addr[$];
    beat_t       cur;
    int          checks = 0;
    int          failures = 0;
    bit          dev_use_const = 1'b0;
    logic [31:0] dev_const = 32'h0;
    logic [31:0] a_exp;

    function automatic logic [31:0] devword(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Registered device: word appears the cycle after devread.
    always @(posedge ACLK)
        if (devread)
            data_in <= dev_use_const ? dev_const : devword(address_out);

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(logic [31:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic exp_beat(logic [31:0] d, logic [3:0] id,
                            logic [1:0] r, logic l);
        beat_t b;
        b.data = d; b.id = id; b.resp = r; b.last = l;
        exp_beats.push_back(b);
    endtask

    // Monitor: device reads and R handshakes against the scoreboard.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            if (devread) begin
                if (exp_addr.size() == 0) begin
                    chk("devread_unexpected", {31'd0, devread}, 64'd0);
                end else begin
                    a_exp = exp_addr.pop_front();
                    chk("address_out", address_out, a_exp);
                end
            end
            if (RVALID && RREADY) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", {31'd0, RVALID}, 64'd0);
                end else begin
                    cur = exp_beats.pop_front();
                    chk("RDATA", RDATA, cur.data);
                    chk("RID", RID, cur.id);
                    chk("RESP", RESP, cur.resp);
                    chk("RLAST", RLAST, cur.last);
                end
            end
        end
    end

    task automatic send_ar(logic [3:0] id, logic [31:0] a, logic [3:0] len,
                           logic [2:0] sz, logic [1:0] bt);
        int n = 0;
        @(posedge ACLK); #1;
        ARID = id; ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bt;
        ARPROT = 3'b010; ARVALID = 1'b1;
        forever begin
            @(negedge ACLK);
            if (ARREADY || n >= 50) break;
            n++;
        end
        chk("ar_accept_timeout", {31'd0, ARREADY}, 64'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (exp_beats.size() != 0 && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        chk({tag, "_beats_left"}, exp_beats.size(), 0);
        @(negedge ACLK);
        @(negedge ACLK);
        chk({tag, "_arready"}, {31'd0, ARREADY}, 64'd1);
        chk({tag, "_reads_left"}, exp_addr.size(), 0);
    endtask

    initial begin
        int lat;
        int n;
        ARESETn = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1; data_in = '0;

        // Reset state.
        repeat (3) @(negedge ACLK);
        chk("rst_ARREADY", {31'd0, ARREADY}, 64'd0);
        chk("rst_RVALID", {31'd0, RVALID}, 64'd0);
        chk("rst_devread", {31'd0, devread}, 64'd0);
        chk("rst_RLAST", {31'd0, RLAST}, 64'd0);
        chk("rst_RDATA", RDATA, 64'd0);
        chk("rst_RID", RID, 64'd0);
        chk("rst_RESP", RESP, 64'd0);
        chk("rst_address_out", address_out, 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk("rel_ARREADY_pre_edge", {31'd0, ARREADY}, 64'd0);
        @(negedge ACLK);
        chk("rel_ARREADY_post_edge", {31'd0, ARREADY}, 64'd1);

        // INCR 0x100, 4 words; RVALID seen on the 3rd edge counting the AR edge.
        for (int i = 0; i < 4; i++) begin
            exp_rd(32'h100 + 32'(4 * i));
            exp_beat(devword(32'h100 + 32'(4 * i)), 4'h5, 2'b00, i == 3);
        end
        send_ar(4'h5, 32'h100, 4'd3, 3'd2, 2'b01);
        lat = 0;
        do begin
            @(negedge ACLK);
            lat++;
        end while (!RVALID && lat < 20);
        chk("first_rvalid_edges", lat, 3);
        wait_done("incr");

        // WRAP 0x38, 4 words: 38, 3C, 30, 34.
        exp_rd(32'h38); exp_beat(devword(32'h38), 4'hA, 2'b00, 1'b0);
        exp_rd(32'h3C); exp_beat(devword(32'h3C), 4'hA, 2'b00, 1'b0);
        exp_rd(32'h30); exp_beat(devword(32'h30), 4'hA, 2'b00, 1'b0);
        exp_rd(32'h34); exp_beat(devword(32'h34), 4'hA, 2'b00, 1'b1);
        send_ar(4'hA, 32'h38, 4'd3, 3'd2, 2'b10);
        wait_done("wrap");

        // FIXED byte at 0x21: lane 1 only, address held.
        dev_use_const = 1'b1;
        dev_const = 32'hAABBCCDD;
        exp_rd(32'h20); exp_beat(32'h0000CC00, 4'h3, 2'b00, 1'b0);
        exp_rd(32'h20); exp_beat(32'h0000CC00, 4'h3, 2'b00, 1'b1);
        send_ar(4'h3, 32'h21, 4'd1, 3'd0, 2'b00);
        wait_done("fixed");
        dev_use_const = 1'b0;

        // Unaligned INCR word at 0x102.
        exp_rd(32'h100); exp_beat(devword(32'h100) & 32'hFFFF0000, 4'h7, 2'b00, 1'b0);
        exp_rd(32'h104); exp_beat(devword(32'h104), 4'h7, 2'b00, 1'b1);
        send_ar(4'h7, 32'h102, 4'd1, 3'd2, 2'b01);
        wait_done("unaligned");

        // Oversized WRAP with bad length: 3 SLVERR beats, no device reads.
        for (int i = 0; i < 3; i++)
            exp_beat(32'h0, 4'h9, 2'b10, i == 2);
        send_ar(4'h9, 32'h40, 4'd2, 3'd3, 2'b10);
        wait_done("err_wrap");

        // Reserved burst type: single SLVERR beat.
        exp_beat(32'h0, 4'h1, 2'b10, 1'b1);
        send_ar(4'h1, 32'h80, 4'd0, 3'd2, 2'b11);
        wait_done("err_rsvd");

        // Backpressure: first beat must hold for 5 cycles.
        RREADY = 1'b0;
        exp_rd(32'h200); exp_beat(devword(32'h200), 4'h2, 2'b00, 1'b0);
        exp_rd(32'h204); exp_beat(devword(32'h204), 4'h2, 2'b00, 1'b1);
        send_ar(4'h2, 32'h200, 4'd1, 3'd2, 2'b01);
        n = 0;
        while (!RVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("bp_RVALID", {31'd0, RVALID}, 64'd1);
            chk("bp_RDATA", RDATA, devword(32'h200));
            chk("bp_RLAST", {31'd0, RLAST}, 64'd0);
            chk("bp_devread", {31'd0, devread}, 64'd0);
        end
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        wait_done("backpressure");

        // Reset while a beat is pending.
        RREADY = 1'b0;
        exp_rd(32'h300);
        send_ar(4'h4, 32'h300, 4'd15, 3'd2, 2'b01);
        n = 0;
        while (!RVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("mid_RVALID_before_reset", {31'd0, RVALID}, 64'd1);
        #1 ARESETn = 1'b1;
        #1;
        chk("mid_RVALID_async_drop", {31'd0, RVALID}, 64'd0);
        chk("mid_ARREADY_in_reset", {31'd0, ARREADY}, 64'd0);
        chk("mid_reads_left", exp_addr.size(), 0);
        exp_addr.delete();
        exp_beats.delete();
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("mid_ARREADY_pre_edge", {31'd0, ARREADY}, 64'd0);
        @(negedge ACLK);
        chk("mid_ARREADY_post_edge", {31'd0, ARREADY}, 64'd1);

        exp_rd(32'h300); exp_beat(devword(32'h300), 4'h6, 2'b00, 1'b0);
        exp_rd(32'h304); exp_beat(devword(32'h304), 4'h6, 2'b00, 1'b1);
        send_ar(4'h6, 32'h300, 4'd1, 3'd2, 2'b01);
        wait_done("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
